// File: rtl/stereo_disparity_engine_if.sv
// rtl/stereo_disparity_engine_if.sv - pixel-pair input and disparity result handshake bundle
interface stereo_disparity_engine_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DW          = 4,
  parameter int SW          = 12
);
  logic                   data_valid_in;
  logic                   ready_out;
  logic [PIXEL_WIDTH-1:0] left_pixel_in;
  logic [PIXEL_WIDTH-1:0] right_pixel_in;
  logic [10:0]            hcount_in;
  logic [9:0]             vcount_in;
  logic                   data_valid_out;
  logic                   ready_in;
  logic [DW-1:0]          disparity_out;
  logic [SW-1:0]          sad_out;
  logic                   border_out;
  logic [10:0]            hcount_out;
  logic [9:0]             vcount_out;

  modport master (
    output data_valid_in, left_pixel_in, right_pixel_in, hcount_in, vcount_in, ready_in,
    input  ready_out, data_valid_out, disparity_out, sad_out, border_out, hcount_out, vcount_out
  );

  modport slave (
    input  data_valid_in, left_pixel_in, right_pixel_in, hcount_in, vcount_in, ready_in,
    output ready_out, data_valid_out, disparity_out, sad_out, border_out, hcount_out, vcount_out
  );
endinterface

// File: rtl/stereo_disparity_engine.sv
// rtl/stereo_disparity_engine.sv - sequential SAD block-matching stereo disparity engine
module stereo_disparity_engine #(
  parameter int HRES         = 640,
  parameter int VRES         = 360,
  parameter int PIXEL_WIDTH  = 8,
  parameter int KERNEL_WIDTH = 3,
  parameter int MAX_DISP     = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  stereo_disparity_engine_if.slave   bus
);
  localparam int K       = KERNEL_WIDTH;
  localparam int M       = MAX_DISP;
  localparam int PW      = PIXEL_WIDTH;
  localparam int DW      = $clog2(MAX_DISP);
  localparam int SW      = PIXEL_WIDTH + $clog2(K * K);
  localparam int HIST    = K + M - 1;
  localparam int AW      = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int LB_ROWS = (K > 1) ? K - 1 : 1;
  localparam logic [10:0]   H_LAST = 11'(HRES - 1);
  localparam logic [9:0]    V_LAST = 10'(VRES - 1);
  localparam logic [10:0]   H_MIN  = 11'(K + M - 2);
  localparam logic [9:0]    V_MIN  = 10'(K - 1);
  localparam logic [DW-1:0] D_LAST = DW'(M - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

  state_t            state, state_nxt;
  logic              started;
  logic              accept;
  logic [PW-1:0]     col_l [K];
  logic [PW-1:0]     col_r [K];
  logic [PW-1:0]     lwin  [K][K];
  logic [PW-1:0]     rhist [HIST][K];
  logic [PW-1:0]     rwin  [K][K];
  logic [10:0]       hc_q;
  logic [9:0]        vc_q;
  logic              border_q;
  logic [DW-1:0]     d;
  logic [DW-1:0]     best_d;
  logic [SW-1:0]     best_sad;
  logic [SW-1:0]     sad_cur;
  logic [DW-1:0]     disp_q;
  logic [SW-1:0]     sad_q;
  logic              bord_q;
  logic [10:0]       hco_q;
  logic [9:0]        vco_q;

  assign accept             = bus.data_valid_in && bus.ready_out;
  assign bus.ready_out      = started && (state == IDLE);
  assign bus.data_valid_out = (state == DONE);
  assign bus.disparity_out  = disp_q;
  assign bus.sad_out        = sad_q;
  assign bus.border_out     = bord_q;
  assign bus.hcount_out     = hco_q;
  assign bus.vcount_out     = vco_q;

  // Each row buffer shifts up one row per column write, so row 0 is always the oldest line.
  if (K > 1) begin : g_lb
    logic [PW-1:0] lb_l [LB_ROWS][HRES];
    logic [PW-1:0] lb_r [LB_ROWS][HRES];
    logic [AW-1:0] addr;
    logic          in_range;

    assign addr     = bus.hcount_in[AW-1:0];
    assign in_range = (bus.hcount_in <= H_LAST);

    always_ff @(posedge clk_in) begin
      if (accept) begin
        for (int r = 0; r < K - 1; r++) begin
          col_l[r] <= lb_l[r][addr];
          col_r[r] <= lb_r[r][addr];
        end
        col_l[K-1] <= bus.left_pixel_in;
        col_r[K-1] <= bus.right_pixel_in;
        if (in_range) begin
          for (int r = 0; r < K - 2; r++) begin
            lb_l[r][addr] <= lb_l[r+1][addr];
            lb_r[r][addr] <= lb_r[r+1][addr];
          end
          lb_l[K-2][addr] <= bus.left_pixel_in;
          lb_r[K-2][addr] <= bus.right_pixel_in;
        end
      end
    end
  end else begin : g_no_lb
    always_ff @(posedge clk_in) begin
      if (accept) begin
        col_l[0] <= bus.left_pixel_in;
        col_r[0] <= bus.right_pixel_in;
      end
    end
  end

  function automatic logic [PW-1:0] absdiff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  always_comb begin
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++)
        rwin[c][r] = rhist[c][r];
    for (int dd = 1; dd < M; dd++)
      if (d == DW'(dd))
        for (int c = 0; c < K; c++)
          for (int r = 0; r < K; r++)
            rwin[c][r] = rhist[c+dd][r];
  end

  always_comb begin
    sad_cur = '0;
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++)
        sad_cur = sad_cur + SW'(absdiff(lwin[c][r], rwin[c][r]));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = border_q ? DONE : SEARCH;
      SEARCH:  if (d == D_LAST) state_nxt = DONE;
      DONE:    if (bus.ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      started  <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      border_q <= 1'b0;
      d        <= '0;
      best_d   <= '0;
      best_sad <= '0;
      disp_q   <= '0;
      sad_q    <= '0;
      bord_q   <= 1'b0;
      hco_q    <= '0;
      vco_q    <= '0;
      for (int c = 0; c < K; c++)
        for (int r = 0; r < K; r++)
          lwin[c][r] <= '0;
      for (int c = 0; c < HIST; c++)
        for (int r = 0; r < K; r++)
          rhist[c][r] <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          hc_q     <= bus.hcount_in;
          vc_q     <= bus.vcount_in;
          // Out-of-frame coordinates are treated as border so a bad source cannot index past the buffers.
          border_q <= (bus.vcount_in < V_MIN) || (bus.hcount_in < H_MIN) ||
                      (bus.hcount_in > H_LAST) || (bus.vcount_in > V_LAST);
        end
        LOAD: begin
          for (int r = 0; r < K; r++) begin
            for (int c = K - 1; c > 0; c--) lwin[c][r] <= lwin[c-1][r];
            for (int c = HIST - 1; c > 0; c--) rhist[c][r] <= rhist[c-1][r];
            lwin[0][r]  <= col_l[r];
            rhist[0][r] <= col_r[r];
          end
          if (border_q) begin
            disp_q <= '0;
            sad_q  <= '0;
            bord_q <= 1'b1;
            hco_q  <= hc_q;
            vco_q  <= vc_q;
          end else begin
            d        <= '0;
            best_d   <= '0;
            best_sad <= '1;
          end
        end
        SEARCH: begin
          d <= d + 1'b1;
          if (sad_cur < best_sad) begin
            best_sad <= sad_cur;
            best_d   <= d;
          end
          if (d == D_LAST) begin
            disp_q <= (sad_cur < best_sad) ? d : best_d;
            sad_q  <= (sad_cur < best_sad) ? sad_cur : best_sad;
            bord_q <= 1'b0;
            hco_q  <= hc_q;
            vco_q  <= vc_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
